// File: rtl/vga_sync_gen_if.sv
// Beam position and sync bundle from vga_sync_gen to every pixel consumer.
interface vga_sync_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       frame_start;

  modport master (
    output x, y, hsync, vsync, video_on, p_tick, frame_start
  );

  modport slave (
    input x, y, hsync, vsync, video_on, p_tick, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing: pixel-rate divider, h/v beam counters and registered sync outputs.
// Define VGA_FRAME_TICK_EN to build the frame_start pulse at (0,0); otherwise it is tied low.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic             en;
  logic [9:0]       h;
  logic [9:0]       v;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             video_on_q;
  logic             p_tick_q;

  assign en = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (en) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // v only moves on the pixel that wraps h, so a line is never split across frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // Outputs sample the pre-advance counters, so everything lags the counters by one pixel together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      p_tick_q   <= 1'b0;
    end else begin
      p_tick_q <= en;
      if (en) begin
        x_q        <= h;
        y_q        <= v;
        video_on_q <= (h < H_VIS) && (v < V_VIS);
        hsync_q    <= !((h >= HS_FIRST) && (h <= HS_LAST));
        vsync_q    <= !((v >= VS_FIRST) && (v <= VS_LAST));
      end
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic frame_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= en && (h == '0) && (v == '0);
    end
  end

  assign vga.frame_start = frame_start_q;
`else
  assign vga.frame_start = 1'b0;
`endif

  assign vga.x        = x_q;
  assign vga.y        = y_q;
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = video_on_q;
  assign vga.p_tick   = p_tick_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance for startup/line timing, a shrunken instance for frame-level timing.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vd ();
  vga_sync_gen_if vs ();

  vga_sync_gen u_dut_d (
    .clk (clk),
    .rst (rst_d),
    .vga (vd)
  );

  // Small timing: H_TOTAL 16 (hsync low 10..12), V_TOTAL 11 (vsync low 7..8), 176 pixels per frame.
  vga_sync_gen #(
    .CLK_DIV (2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_dut_s (
    .clk (clk),
    .rst (rst_s),
    .vga (vs)
  );

  localparam logic [24:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    logic [24:0] got;
    logic [21:0] got_s;
    logic [21:0] exp_s;
    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (10) @(negedge clk);
    got = {vd.x, vd.y, vd.hsync, vd.vsync, vd.video_on, vd.p_tick, vd.frame_start};
    checks++;
    if (got !== RST_VEC) begin
      errors++;
      $display("FAIL reset_d got %h want %h", got, RST_VEC);
    end
    got = {vs.x, vs.y, vs.hsync, vs.vsync, vs.video_on, vs.p_tick, vs.frame_start};
    checks++;
    if (got !== RST_VEC) begin
      errors++;
      $display("FAIL reset_s got %h want %h", got, RST_VEC);
    end
    rst_d = 1'b0;
    repeat (3) @(negedge clk);
    got = {vd.x, vd.y, vd.hsync, vd.vsync, vd.video_on, vd.p_tick, vd.frame_start};
    checks++;
    if (got !== RST_VEC) begin
      errors++;
      $display("FAIL pre_first_en got %h want %h", got, RST_VEC);
    end
    @(negedge clk);
    got_s = {vd.x, vd.y, vd.video_on, vd.p_tick};
`ifdef VGA_FRAME_TICK_EN
    exp_s = {10'd0, 10'd0, 1'b1, 1'b1} ^ 22'd0;
    checks++;
    if (vd.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_start got %b want 1", vd.frame_start);
    end
`else
    exp_s = {10'd0, 10'd0, 1'b1, 1'b1};
`endif
    checks++;
    if (got_s !== exp_s) begin
      errors++;
      $display("FAIL first_en got %h want %h", got_s, exp_s);
    end
    @(negedge clk);
    checks++;
    if (vd.p_tick !== 1'b0 || vd.x !== 10'd0 || vd.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL p_tick_pulse got p_tick=%b x=%0d fs=%b want 0/0/0", vd.p_tick, vd.x, vd.frame_start);
    end
  endtask

  task automatic test_line_wrap();
    int ex = 0;
    int ey = 0;
    int n = 1;
    int run = 0;
    int run_start = 0;
    int runs = 0;
    logic [21:0] got;
    logic [21:0] exp;
    for (int t = 1; t <= 1600; t++) begin
      do begin
        @(negedge clk);
        n++;
      end while (!vd.p_tick && n < 10);
      checks++;
      if (n !== 4) begin
        errors++;
        $display("FAIL d_tick_period t=%0d got %0d clks want 4", t, n);
      end
      n = 0;
      if (ex == 799) begin
        ex = 0;
        ey++;
      end else begin
        ex++;
      end
      exp = {10'(ex), 10'(ey), (ex < 640 && ey < 480), !(ex >= 656 && ex <= 751)};
      got = {vd.x, vd.y, vd.video_on, vd.hsync};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL d_pixel t=%0d got x=%0d y=%0d von=%b hs=%b want x=%0d y=%0d von=%b hs=%b",
                 t, vd.x, vd.y, vd.video_on, vd.hsync, ex, ey, exp[1], exp[0]);
      end
      if (vd.hsync === 1'b0) begin
        if (run == 0) run_start = int'(vd.x);
        run++;
      end else if (run != 0) begin
        checks++;
        runs++;
        if (run !== 96 || run_start !== 656) begin
          errors++;
          $display("FAIL hsync_run got len=%0d start=%0d want 96/656", run, run_start);
        end
        run = 0;
      end
    end
    checks++;
    if (runs !== 2) begin
      errors++;
      $display("FAIL hsync_run_count got %0d want 2", runs);
    end
  endtask

  task automatic test_frame();
    int ex = 0;
    int ey = 0;
    int n = 0;
    int vlow = 0;
    int fs_cnt = 0;
    logic efs;
    logic [23:0] got;
    logic [23:0] exp;
    rst_s = 1'b0;
    for (int t = 0; t <= 352; t++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!vs.p_tick) begin
          checks++;
          if (vs.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_off_tick t=%0d got %b want 0", t, vs.frame_start);
          end
        end
      end while (!vs.p_tick && n < 10);
      checks++;
      if (n !== 2) begin
        errors++;
        $display("FAIL s_tick_period t=%0d got %0d clks want 2", t, n);
      end
`ifdef VGA_FRAME_TICK_EN
      efs = (ex == 0 && ey == 0);
`else
      efs = 1'b0;
`endif
      exp = {10'(ex), 10'(ey), (ex < 8 && ey < 6), !(ex >= 10 && ex <= 12), !(ey >= 7 && ey <= 8), efs};
      got = {vs.x, vs.y, vs.video_on, vs.hsync, vs.vsync, vs.frame_start};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL s_pixel t=%0d got %h want %h", t, got, exp);
      end
      if (t < 176 && vs.vsync === 1'b0) vlow++;
      if (vs.frame_start === 1'b1) fs_cnt++;
      if (ex == 15) begin
        ex = 0;
        ey = (ey == 10) ? 0 : ey + 1;
      end else begin
        ex++;
      end
    end
    checks++;
    if (vlow !== 32) begin
      errors++;
      $display("FAIL vsync_len got %0d ticks want 32", vlow);
    end
    checks++;
`ifdef VGA_FRAME_TICK_EN
    if (fs_cnt !== 3) begin
      errors++;
      $display("FAIL fs_count got %0d want 3", fs_cnt);
    end
`else
    if (fs_cnt !== 0) begin
      errors++;
      $display("FAIL fs_count got %0d want 0", fs_cnt);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int k;
    int n;
    logic [24:0] got;
    k = 0;
    while (!(vd.p_tick === 1'b1 && vd.x === 10'd300) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 2000) begin
      errors++;
      $display("FAIL d_reach_300 got timeout want x=300");
    end
    #2 rst_d = 1'b1;
    #1;
    got = {vd.x, vd.y, vd.hsync, vd.vsync, vd.video_on, vd.p_tick, vd.frame_start};
    checks++;
    if (got !== RST_VEC) begin
      errors++;
      $display("FAIL d_async_reset got %h want %h", got, RST_VEC);
    end
    repeat (3) @(negedge clk);
    rst_d = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vd.p_tick && n < 10);
    checks++;
    if (n !== 4 || vd.x !== 10'd0 || vd.y !== 10'd0 || vd.video_on !== 1'b1) begin
      errors++;
      $display("FAIL d_restart got clks=%0d x=%0d y=%0d von=%b want 4/0/0/1", n, vd.x, vd.y, vd.video_on);
    end

    k = 0;
    while (!(vs.p_tick === 1'b1 && vs.x === 10'd3 && vs.y === 10'd4) && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 500) begin
      errors++;
      $display("FAIL s_reach_3_4 got timeout want x=3 y=4");
    end
    #2 rst_s = 1'b1;
    #1;
    got = {vs.x, vs.y, vs.hsync, vs.vsync, vs.video_on, vs.p_tick, vs.frame_start};
    checks++;
    if (got !== RST_VEC) begin
      errors++;
      $display("FAIL s_async_reset got %h want %h", got, RST_VEC);
    end
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vs.p_tick && n < 10);
    checks++;
    if (n !== 2 || vs.x !== 10'd0 || vs.y !== 10'd0 || vs.video_on !== 1'b1) begin
      errors++;
      $display("FAIL s_restart got clks=%0d x=%0d y=%0d von=%b want 2/0/0/1", n, vs.x, vs.y, vs.video_on);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (vs.p_tick !== 1'b1 || vs.x !== 10'd1 || vs.y !== 10'd0) begin
      errors++;
      $display("FAIL s_restart_next got p_tick=%b x=%0d y=%0d want 1/1/0", vs.p_tick, vs.x, vs.y);
    end
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_frame();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
